// File: rtl/button_capture_pkg.sv
// Shared constants for the button capture block: register map, bus width and
// the helper that sizes every cycle counter.
package button_capture_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] ADDR_LEVEL     = 2'd0;
   localparam logic [1:0] ADDR_CAPTURE   = 2'd1;
   localparam logic [1:0] ADDR_MASK      = 2'd2;
   localparam logic [1:0] ADDR_REPEAT_EN = 2'd3;

   // Wide enough for the largest cycle count plus one spare bit for saturation.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/button_capture_if.sv
// Avalon-MM slave port of the button capture block (read latency 1).
interface button_capture_if;
   import button_capture_pkg::*;

   logic [1:0]        address;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;

   modport master (output address, read, write, writedata, input readdata);
   modport slave  (input address, read, write, writedata, output readdata);

endinterface

// File: rtl/button_capture_debounce.sv
// One button: two-flop synchroniser, debounce counter, press-edge detect and
// auto-repeat timer. evt pulses for one cycle on a press or a repeat tick.
module button_debounce
   import button_capture_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES      = 500000,
   parameter int REPEAT_DELAY_CYCLES  = 25000000,
   parameter int REPEAT_PERIOD_CYCLES = 5000000,
   parameter int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   input  logic repeat_en,
   output logic level,
   output logic evt
);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY_CYCLES);
   localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_PERIOD_CYCLES);

   logic             s1, s2, level_d, rep_phase, active, rep_fire;
   logic [CNT_W-1:0] db_cnt, hold_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1      <= 1'b1;
         s2      <= 1'b1;
         level   <= 1'b0;
         level_d <= 1'b0;
         db_cnt  <= '0;
      end else begin
         s1      <= key_n;
         s2      <= s1;
         level_d <= level;
         if (~s2 == level) db_cnt <= '0;
         else if (db_cnt == DB_LAST) begin
            level  <= ~level;
            db_cnt <= '0;
         end else if (~&db_cnt) db_cnt <= db_cnt + 1'b1;
      end
   end

   // hold_cnt is 0 on the first active cycle (the press cycle); after the first
   // tick it restarts at 1 so later ticks land every REPEAT_PERIOD_CYCLES.
   assign active   = repeat_en & level;
   assign rep_fire = active & (rep_phase ? (hold_cnt == REP_NEXT) : (hold_cnt == REP_FIRST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt  <= '0;
         rep_phase <= 1'b0;
      end else if (!active) begin
         hold_cnt  <= '0;
         rep_phase <= 1'b0;
      end else if (rep_fire) begin
         hold_cnt  <= CNT_W'(1);
         rep_phase <= 1'b1;
      end else if (~&hold_cnt) hold_cnt <= hold_cnt + 1'b1;
   end

   assign evt = (level & ~level_d) | rep_fire;

endmodule

// File: rtl/button_capture.sv
// Debounced push-button capture with W1C event register, interrupt mask and
// auto-repeat, exposed as an Avalon-MM slave.
module button_capture
   import button_capture_pkg::*;
#(
   parameter int NUM_BUTTONS          = 4,
   parameter int DEBOUNCE_CYCLES      = 500000,
   parameter int REPEAT_DELAY_CYCLES  = 25000000,
   parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] key_n,
   button_capture_if.slave        bus,
   output logic                   irq
);

   // Registers are kept bus-wide; bits above NUM_BUTTONS are forced to zero.
   localparam logic [DATA_W-1:0] BTN_MASK = DATA_W'({NUM_BUTTONS{1'b1}});

   logic [NUM_BUTTONS-1:0] level, evt;
   logic [DATA_W-1:0]      cap_q, mask_q, ren_q, rd_mux, wdata, cap_clr;

   button_debounce #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
   ) u_deb [NUM_BUTTONS-1:0] (
      .clk      (clk),
      .reset    (reset),
      .key_n    (key_n),
      .repeat_en(ren_q[NUM_BUTTONS-1:0]),
      .level    (level),
      .evt      (evt)
   );

   assign wdata   = bus.writedata & BTN_MASK;
   assign cap_clr = (bus.write && bus.address == ADDR_CAPTURE) ? wdata : '0;

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_LEVEL:     rd_mux = DATA_W'(level);
         ADDR_CAPTURE:   rd_mux = cap_q;
         ADDR_MASK:      rd_mux = mask_q;
         ADDR_REPEAT_EN: rd_mux = ren_q;
         default:        rd_mux = '0;
      endcase
   end

   // Event OR'd in after the clear so a same-cycle press survives a W1C write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_q        <= '0;
         mask_q       <= '0;
         ren_q        <= '0;
         irq          <= 1'b0;
         bus.readdata <= '0;
      end else begin
         cap_q <= (cap_q & ~cap_clr) | DATA_W'(evt);
         if (bus.write && bus.address == ADDR_MASK)      mask_q <= wdata;
         if (bus.write && bus.address == ADDR_REPEAT_EN) ren_q  <= wdata;
         irq <= |(cap_q & mask_q);
         if (bus.read) bus.readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_button_capture.sv
// Randomised and directed bench for button_capture against a windowed-history
// reference model with arithmetic repeat timing.
module tb_button_capture;
   import button_capture_pkg::*;

   localparam int N  = 4;
   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] key_n = '1;
   logic         irq;

   button_capture_if bus();

   button_capture #(
      .NUM_BUTTONS(N), .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)
   ) dut (
      .clk(clk), .reset(reset), .key_n(key_n), .bus(bus), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: state as seen just after each clock edge.
   logic [N-1:0]    m_s1, m_s2, m_lvl, m_lvl_d, m_cap, m_mask, m_ren;
   logic [DB-1:0]   hist [N];
   int              start [N];
   logic [31:0]     m_rd;
   logic            m_irq;
   int              cyc = 0;

   task automatic model_reset();
      m_s1 = '1; m_s2 = '1; m_lvl = '0; m_lvl_d = '0;
      m_cap = '0; m_mask = '0; m_ren = '0; m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < N; i++) begin
         hist[i]  = '0;
         start[i] = -1;
      end
   endtask

   task automatic model_step();
      logic [N-1:0] ev, ps, nl, wd;
      logic [31:0]  mux;
      int k;
      if (!reset) model_reset();
      else begin
         ps = ~m_s2;
         for (int i = 0; i < N; i++) begin
            ev[i] = m_lvl[i] & ~m_lvl_d[i];
            if (m_ren[i] && m_lvl[i]) begin
               if (start[i] < 0) start[i] = cyc;
               k = cyc - start[i];
               if (k == RD || (k > RD && (k - RD) % RP == 0)) ev[i] = 1'b1;
            end else start[i] = -1;
         end
         case (bus.address)
            2'd0: mux = 32'(m_lvl);
            2'd1: mux = 32'(m_cap);
            2'd2: mux = 32'(m_mask);
            default: mux = 32'(m_ren);
         endcase
         if (bus.read) m_rd = mux;
         m_irq = |(m_cap & m_mask);
         wd = bus.writedata[N-1:0];
         if (bus.write && bus.address == 2'd1) m_cap = (m_cap & ~wd) | ev;
         else m_cap = m_cap | ev;
         if (bus.write && bus.address == 2'd2) m_mask = wd;
         if (bus.write && bus.address == 2'd3) m_ren = wd;
         // Level flips once the last DB synchronised samples all disagree with it.
         nl = m_lvl;
         for (int i = 0; i < N; i++) begin
            hist[i] = {hist[i][DB-2:0], ps[i]};
            if (m_lvl[i] ? (hist[i] == '0) : (hist[i] == '1)) nl[i] = ~m_lvl[i];
         end
         m_lvl_d = m_lvl;
         m_lvl   = nl;
         m_s2    = m_s1;
         m_s1    = key_n;
      end
      cyc++;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         model_step();
         #1;
         check("readdata", bus.readdata, m_rd);
         check("irq", 32'(irq), 32'(m_irq));
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.read = 1'b0; bus.write = 1'b0;
      end
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.address = a; bus.read = 1'b1; bus.write = 1'b0;
      @(negedge clk);
      bus.read = 1'b0;
      d = bus.readdata;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address = a; bus.writedata = d; bus.write = 1'b1; bus.read = 1'b0;
      @(negedge clk);
      bus.write = 1'b0;
   endtask

   logic [31:0] rd;
   int          n_ev;

   initial begin
      bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      idle(4);
      for (int a = 0; a < 4; a++) begin
         bus_rd(2'(a), rd);
         check($sformatf("reset_reg%0d", a), rd, 32'h0);
      end
      check("reset_irq", 32'(irq), 32'h0);

      // 3-cycle glitch must not qualify
      @(negedge clk); key_n[0] = 1'b0;
      idle(2);
      @(negedge clk); key_n[0] = 1'b1;
      idle(6);
      bus_rd(ADDR_LEVEL, rd);   check("glitch_level", rd, 32'h0);
      bus_rd(ADDR_CAPTURE, rd); check("glitch_cap", rd, 32'h0);
      @(negedge clk); key_n[0] = 1'b0;
      idle(9);
      bus_rd(ADDR_LEVEL, rd);   check("press_level", rd, 32'h1);
      bus_rd(ADDR_CAPTURE, rd); check("press_cap", rd, 32'h1);
      @(negedge clk); key_n[0] = 1'b1;
      idle(10);

      // interrupt rise and fall
      bus_wr(ADDR_CAPTURE, 32'h1);
      bus_wr(ADDR_MASK, 32'h1);
      idle(2);
      check("irq_idle", 32'(irq), 32'h0);
      @(negedge clk); key_n[0] = 1'b0;
      idle(12);
      check("irq_set", 32'(irq), 32'h1);
      bus_wr(ADDR_CAPTURE, 32'h1);
      idle(1);
      check("irq_clr", 32'(irq), 32'h0);
      @(negedge clk); key_n[0] = 1'b1;
      idle(10);

      // auto-repeat on key 1, read+clear capture every cycle
      bus_wr(ADDR_REPEAT_EN, 32'h2);
      n_ev = 0;
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         if (bus.readdata[1]) n_ev++;
         key_n[1] = (c < 58) ? 1'b0 : 1'b1;
         bus.address = ADDR_CAPTURE; bus.read = 1'b1; bus.write = 1'b1; bus.writedata = 32'h2;
      end
      idle(1);
      check("repeat_events", 32'(n_ev), 32'd6);
      bus_wr(ADDR_REPEAT_EN, 32'h0);
      bus_wr(ADDR_CAPTURE, 32'hF);

      // press event collides with W1C of the same bit
      @(negedge clk); key_n[2] = 1'b0;
      repeat (6) @(negedge clk);
      bus.address = ADDR_CAPTURE; bus.writedata = 32'h4; bus.write = 1'b1;
      @(negedge clk); bus.write = 1'b0;
      bus_rd(ADDR_CAPTURE, rd); check("set_wins", rd, 32'h4);
      @(negedge clk); key_n[2] = 1'b1;
      idle(10);
      bus_wr(ADDR_CAPTURE, 32'hF);

      // reset while key 3 is held
      bus_wr(ADDR_MASK, 32'h8);
      @(negedge clk); key_n[3] = 1'b0;
      idle(12);
      @(negedge clk); reset = 1'b0;
      idle(2);
      @(negedge clk); reset = 1'b1;
      for (int a = 0; a < 4; a++) begin
         bus_rd(2'(a), rd);
         check($sformatf("midrst_reg%0d", a), rd, 32'h0);
      end
      idle(12);
      bus_rd(ADDR_LEVEL, rd);   check("rst_requal_level", rd, 32'h8);
      bus_rd(ADDR_CAPTURE, rd); check("rst_one_event", rd, 32'h8);
      bus_wr(ADDR_CAPTURE, 32'h8);
      idle(30);
      bus_rd(ADDR_CAPTURE, rd); check("rst_no_extra", rd, 32'h0);
      @(negedge clk); key_n[3] = 1'b1;
      idle(10);

      // randomised traffic; per-bit flip rates give glitches, presses and long holds
      for (int c = 0; c < 4000; c++) begin
         int r;
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if ($urandom_range((8 << i) - 1) == 0) key_n[i] = ~key_n[i];
         r = $urandom_range(7);
         bus.address   = 2'($urandom_range(3));
         bus.writedata = $urandom;
         bus.read      = (r < 4);
         bus.write     = (r == 3 || r == 4);
         if (c % 700 == 350) reset = 1'b0;
         else reset = 1'b1;
      end
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
